// File: rtl/result_writeback.sv
// Result write-back: buffers vectors from the vector multiplier in a small skid FIFO
// and streams them into consecutive result-SRAM addresses whenever the write port is granted.
module result_writeback #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int ADDRESSSIZE    = 10,
    parameter int NUM_VECTORS    = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic                                  in_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    input  logic                                  wr_grant,
    output logic                                  sram_we,
    output logic [ADDRESSSIZE-1:0]                sram_addr,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_wdata,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow
);
    localparam int LW = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_VECTORS + 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] NV_C    = CW'(NUM_VECTORS);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q, base_d;
    logic [ADDRESSSIZE-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]          acc_cnt_q, acc_cnt_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]            fill_q, fill_d;
    logic                   overflow_q, overflow_d;
    logic                   sram_we_q, sram_we_d;
    logic [ADDRESSSIZE-1:0] sram_addr_q, sram_addr_d;
    logic [LW-1:0]          sram_wdata_q, sram_wdata_d;
    logic [LW-1:0]          fifo_mem [FIFO_DEPTH];

    logic fifo_empty, fifo_full, pop, push;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == DEPTH_C);
    assign pop  = ((state_q == COLLECT) || (state_q == DRAIN)) && !fifo_empty && wr_grant;
    // A full FIFO still takes the vector when a slot frees up in the same cycle.
    assign push = (state_q == COLLECT) && in_valid && (!fifo_full || pop);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wr_cnt_d     = wr_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        overflow_d   = overflow_q;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    wr_cnt_d   = '0;
                    acc_cnt_d  = '0;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    fill_d     = '0;
                    overflow_d = 1'b0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    // Dropped vectors still count toward the job length.
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (!push) begin
                        overflow_d = 1'b1;
                    end
                    if (acc_cnt_d == NV_C) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            wr_cnt_d     = wr_cnt_q + 1'b1;
            sram_we_d    = 1'b1;
            sram_addr_d  = base_q + wr_cnt_q;
            sram_wdata_d = fifo_mem[rd_ptr_q];
        end
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            wr_cnt_q     <= '0;
            acc_cnt_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            overflow_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wr_cnt_q     <= wr_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            overflow_q   <= overflow_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    // Storage only; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign busy       = (state_q == COLLECT) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: each task runs one scenario and checks its own results.
module tb_result_writeback;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   base_addr;
    logic         in_valid;
    logic [159:0] in_data;
    logic         wr_grant;
    logic         sram_we;
    logic [9:0]   sram_addr;
    logic [159:0] sram_wdata;
    logic         busy;
    logic         done;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [9:0]   wa_q [$];
    logic [159:0] wd_q [$];
    int           wc_q [$];

    result_writeback dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .wr_grant(wr_grant),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sram_we) begin
            wa_q.push_back(sram_addr);
            wd_q.push_back(sram_wdata);
            wc_q.push_back(cyc);
            $display("[TB] cyc %0d write addr=%h data=%h", cyc, sram_addr, sram_wdata);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    function automatic logic [159:0] vec_of(input int tag);
        logic [159:0] v;
        for (int l = 0; l < 8; l++) v[l*20 +: 20] = 20'(tag * 4099 - l * 777 - 5000);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input int tag);
        in_valid = 1'b1;
        in_data = vec_of(tag);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0; wr_grant = 1'b0;
        #1;
        n_tests++;
        if (sram_we !== 1'b0 || sram_addr !== 10'h0 || sram_wdata !== 160'h0) begin
            n_fail++;
            $display("FAIL reset_sram: we=%b addr=%h data=%h expected 0/0/0", sram_we, sram_addr, sram_wdata);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b ovf=%b expected 0/0/0", busy, done, overflow);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        clear_log();
        wr_grant = 1'b1;
        do_start(10'h010);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) send_vec(i);
        wait_done(40, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_done_timeout: done not seen within 40 cycles");
        end
        n_tests++;
        if (wa_q.size() != 8) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes expected 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (wa_q[i] !== 10'(16 + i) || wd_q[i] !== vec_of(i)) begin
                    n_fail++;
                    $display("FAIL basic_write[%0d]: addr=%h data=%h expected addr=%h data=%h",
                             i, wa_q[i], wd_q[i], 10'(16 + i), vec_of(i));
                end
            end
            n_tests++;
            if (done_cyc != wc_q[7] + 1) begin
                n_fail++;
                $display("FAIL basic_done_timing: done at cyc %0d expected %0d", done_cyc, wc_q[7] + 1);
            end
        end
        repeat (3) tick();
        n_tests++;
        if (done_cnt != d0 + 1 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: done pulses=%0d ovf=%b busy=%b expected 1/0/0",
                     done_cnt - d0, overflow, busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_log();
        wr_grant = 1'b0;
        do_start(10'h020);
        for (int i = 0; i < 4; i++) send_vec(i);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovf_early: got %b expected 0", overflow);
        end
        for (int i = 4; i < 8; i++) send_vec(i);
        repeat (3) tick();
        n_tests++;
        if (overflow !== 1'b1 || busy !== 1'b1 || wa_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_stalled: ovf=%b busy=%b writes=%0d expected 1/1/0", overflow, busy, wa_q.size());
        end
        wr_grant = 1'b1;
        wait_done(40, ok);
        n_tests++;
        if (!ok || wa_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: done=%b writes=%0d expected done=1 writes=4", ok, wa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (wa_q[i] !== 10'(32 + i) || wd_q[i] !== vec_of(i)) begin
                    n_fail++;
                    $display("FAIL bp_write[%0d]: addr=%h data=%h expected addr=%h data=%h",
                             i, wa_q[i], wd_q[i], 10'(32 + i), vec_of(i));
                end
            end
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_sticky: ovf=%b expected 1", overflow);
        end
    endtask

    task automatic test_full_pop();
        bit ok;
        clear_log();
        wr_grant = 1'b0;
        do_start(10'h030);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_ovf_cleared: got %b expected 0", overflow);
        end
        for (int i = 0; i < 4; i++) send_vec(i);
        wr_grant = 1'b1;
        for (int i = 4; i < 8; i++) send_vec(i);
        wait_done(40, ok);
        n_tests++;
        if (!ok || wa_q.size() != 8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_result: done=%b writes=%0d ovf=%b expected 1/8/0", ok, wa_q.size(), overflow);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (wa_q[i] !== 10'(48 + i) || wd_q[i] !== vec_of(i)) begin
                    n_fail++;
                    $display("FAIL fp_write[%0d]: addr=%h data=%h expected addr=%h data=%h",
                             i, wa_q[i], wd_q[i], 10'(48 + i), vec_of(i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [9:0] ea;
        clear_log();
        wr_grant = 1'b1;
        do_start(10'h3FE);
        for (int i = 0; i < 8; i++) send_vec(i + 20);
        wait_done(40, ok);
        n_tests++;
        if (!ok || wa_q.size() != 8) begin
            n_fail++;
            $display("FAIL wrap_count: done=%b writes=%0d expected 1/8", ok, wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ea = (i < 2) ? 10'(10'h3FE + i) : 10'(i - 2);
                n_tests++;
                if (wa_q[i] !== ea || wd_q[i] !== vec_of(i + 20)) begin
                    n_fail++;
                    $display("FAIL wrap_write[%0d]: addr=%h expected %h", i, wa_q[i], ea);
                end
            end
        end
    endtask

    task automatic test_stray();
        bit ok;
        int d0;
        clear_log();
        wr_grant = 1'b1;
        send_vec(99);
        send_vec(98);
        repeat (4) tick();
        n_tests++;
        if (wa_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: writes=%0d busy=%b expected 0/0", wa_q.size(), busy);
        end
        d0 = done_cnt;
        do_start(10'h080);
        send_vec(0);
        send_vec(1);
        start = 1'b1;
        base_addr = 10'h200;
        tick();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_busy: got %b expected 1", busy);
        end
        for (int i = 2; i < 8; i++) send_vec(i);
        wait_done(40, ok);
        repeat (2) tick();
        n_tests++;
        if (!ok || wa_q.size() != 8 || done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL stray_job: done=%b writes=%0d pulses=%0d expected 1/8/1", ok, wa_q.size(), done_cnt - d0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (wa_q[i] !== 10'(128 + i) || wd_q[i] !== vec_of(i)) begin
                    n_fail++;
                    $display("FAIL stray_write[%0d]: addr=%h expected %h", i, wa_q[i], 10'(128 + i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        clear_log();
        wr_grant = 1'b1;
        do_start(10'h040);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = vec_of(i + 40);
            tick();
            if (wa_q.size() >= 3) break;
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (sram_we !== 1'b0 || sram_addr !== 10'h0 || sram_wdata !== 160'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: we=%b addr=%h busy=%b expected 0/0/0", sram_we, sram_addr, busy);
        end
        n_tests++;
        if (wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL midrst_prior: writes=%0d expected 3", wa_q.size());
        end else if (wa_q[2] !== 10'h042 || wd_q[2] !== vec_of(42)) begin
            n_fail++;
            $display("FAIL midrst_prior: third addr=%h expected 042", wa_q[2]);
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (wa_q.size() != 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: writes=%0d busy=%b expected 3/0", wa_q.size(), busy);
        end
        clear_log();
        do_start(10'h100);
        for (int i = 0; i < 8; i++) send_vec(i + 60);
        wait_done(40, ok);
        n_tests++;
        if (!ok || wa_q.size() != 8) begin
            n_fail++;
            $display("FAIL midrst_restart: done=%b writes=%0d expected 1/8", ok, wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (wa_q[i] !== 10'(256 + i) || wd_q[i] !== vec_of(i + 60)) begin
                    n_fail++;
                    $display("FAIL midrst_write[%0d]: addr=%h expected %h", i, wa_q[i], 10'(256 + i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_stray();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
